bcd2f32_seq: RTL

//  Sequential BCD fixed-point to IEEE-754 float32 converter; the input-side counterpart of the float32-to-BCD display path.

---
 rtl/f32_pkg.sv | 37 +++
 rtl/bcd2f32_seq_if.sv | 27 ++
 rtl/bcd_mac10.sv | 12 +
 rtl/bcd2f32_seq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/f32_pkg.sv
// Shared float32 constants and types for the BCD entry path.
// Also holds the decimal power helpers used to size the fraction accumulator.
package f32_pkg;

    localparam int          F32_BIAS = 127;
    localparam logic [31:0] F32_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        INT_MAC,
        FRAC_MAC,
        FRAC_GEN,
        NORM,
        PACK,
        DONE
    } state_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } f32_t;

    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Bits needed to hold any value below 10^n.
    function automatic int pow10_bits(input int n);
        return $clog2(pow10(n));
    endfunction

endpackage

// File: rtl/bcd2f32_seq_if.sv
// Handshake and operand/result bundle between a BCD entry source and the converter.
interface bcd2f32_seq_if
    import f32_pkg::*;
#(
    parameter int INT_DIGITS  = 4,
    parameter int FRAC_DIGITS = 4
);

    logic                                    start;
    logic                                    sign_in;
    logic [4*(INT_DIGITS+FRAC_DIGITS)-1:0]   bcd_in;
    logic                                    busy;
    logic                                    done;
    logic                                    err;
    f32_t                                    result;

    modport master (
        output start, sign_in, bcd_in,
        input  busy, done, err, result
    );

    modport slave (
        input  start, sign_in, bcd_in,
        output busy, done, err, result
    );

endinterface

// File: rtl/bcd_mac10.sv
// Unsigned multiply-by-ten and add one BCD digit, built from two shifts.
module bcd_mac10 #(
    parameter int W = 16
) (
    input  logic [W-1:0] acc,
    input  logic [3:0]   digit,
    output logic [W-1:0] acc_next
);

    assign acc_next = (acc << 3) + (acc << 1) + W'(digit);

endmodule

// File: rtl/bcd2f32_seq.sv
// Sequential signed BCD fixed-point to float32 converter, truncating toward zero.
// One shared x10 MAC builds the integer and fraction accumulators a digit per cycle.
module bcd2f32_seq
    import f32_pkg::*;
#(
    parameter int INT_DIGITS  = 4,
    parameter int FRAC_DIGITS = 4,
    parameter int FRAC_BITS   = 40,
    parameter int IW          = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    bcd2f32_seq_if.slave bus
);

    localparam int N     = INT_DIGITS + FRAC_DIGITS;
    localparam int BCD_W = 4 * N;
    localparam int FA_W  = pow10_bits(FRAC_DIGITS) + 1;
    localparam int MAC_W = (IW > FA_W) ? IW : FA_W;
    localparam int FX_W  = IW + FRAC_BITS;
    localparam int DI_W  = (N > 1) ? $clog2(N) : 1;
    localparam int BC_W  = $clog2(FRAC_BITS + 1);
    localparam int SC_W  = $clog2(FX_W);
    localparam logic [FA_W-1:0] TEN_POW = FA_W'(pow10(FRAC_DIGITS));
    localparam logic [7:0]      EXP_TOP = 8'(F32_BIAS + IW - 1);

    state_t               state, state_nx;
    logic [BCD_W-1:0]     bcd_r;
    logic                 sign_r;
    logic [IW-1:0]        int_acc;
    logic [FA_W-1:0]      f_acc;
    logic [FRAC_BITS-1:0] frac_sr;
    logic [FX_W-1:0]      fx;
    logic [DI_W-1:0]      dig_idx;
    logic [BC_W-1:0]      bit_cnt;
    logic [SC_W-1:0]      s_cnt;
    logic                 err_r;
    f32_t                 result_r;

    logic [3:0]           digit;
    logic                 any_bad;
    logic [MAC_W-1:0]     mac_in;
    logic [MAC_W-1:0]     mac_out;
    logic [FA_W-1:0]      f_dbl;
    logic                 f_ge;
    logic                 int_last;
    logic                 frac_last;
    logic                 gen_last;
    logic                 fx_zero;
    logic                 fx_norm;
    f32_t                 packed_f;

    assign digit     = bcd_r[{dig_idx, 2'b00} +: 4];
    assign int_last  = (dig_idx == DI_W'(FRAC_DIGITS));
    assign frac_last = (dig_idx == '0);
    assign gen_last  = (bit_cnt == BC_W'(FRAC_BITS - 1));
    assign fx_zero   = (fx == '0);
    assign fx_norm   = fx[FX_W-1];

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < N; i++)
            if (bcd_r[4*i +: 4] > 4'd9) any_bad = 1'b1;
    end

    // The single MAC serves the integer digits first, then the fraction digits.
    assign mac_in = (state == INT_MAC) ? MAC_W'(int_acc) : MAC_W'(f_acc);

    bcd_mac10 #(.W(MAC_W)) u_mac (
        .acc      (mac_in),
        .digit    (digit),
        .acc_next (mac_out)
    );

    // Long division of the decimal fraction by 10^FRAC_DIGITS, one quotient bit per cycle.
    assign f_dbl = {f_acc[FA_W-2:0], 1'b0};
    assign f_ge  = (f_dbl >= TEN_POW);

    assign packed_f.sign = sign_r;
    assign packed_f.exp  = EXP_TOP - 8'(s_cnt);
    assign packed_f.mant = fx[FX_W-2 -: 23];

    assign bus.err    = err_r;
    assign bus.result = result_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        bus.busy = (state != IDLE) && (state != DONE);
        bus.done = (state == DONE);
        unique case (state)
            IDLE:     if (bus.start) state_nx = CHECK;
            CHECK:    state_nx = any_bad ? DONE : INT_MAC;
            INT_MAC:  if (int_last) state_nx = FRAC_MAC;
            FRAC_MAC: if (frac_last) state_nx = FRAC_GEN;
            FRAC_GEN: if (gen_last) state_nx = NORM;
            NORM: begin
                if (fx_zero)      state_nx = DONE;
                else if (fx_norm) state_nx = PACK;
            end
            PACK:     state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_r    <= '0;
            sign_r   <= 1'b0;
            int_acc  <= '0;
            f_acc    <= '0;
            frac_sr  <= '0;
            fx       <= '0;
            dig_idx  <= '0;
            bit_cnt  <= '0;
            s_cnt    <= '0;
            err_r    <= 1'b0;
            result_r <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        bcd_r   <= bus.bcd_in;
                        sign_r  <= bus.sign_in;
                        int_acc <= '0;
                        f_acc   <= '0;
                        frac_sr <= '0;
                        dig_idx <= DI_W'(N - 1);
                        bit_cnt <= '0;
                        s_cnt   <= '0;
                    end
                end
                CHECK: begin
                    err_r <= any_bad;
                    if (any_bad) result_r <= F32_QNAN;
                end
                INT_MAC: begin
                    int_acc <= mac_out[IW-1:0];
                    dig_idx <= dig_idx - 1'b1;
                end
                FRAC_MAC: begin
                    f_acc   <= mac_out[FA_W-1:0];
                    dig_idx <= dig_idx - 1'b1;
                end
                FRAC_GEN: begin
                    f_acc   <= f_ge ? (f_dbl - TEN_POW) : f_dbl;
                    frac_sr <= {frac_sr[FRAC_BITS-2:0], f_ge};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (gen_last) fx <= {int_acc, frac_sr[FRAC_BITS-2:0], f_ge};
                end
                NORM: begin
                    if (fx_zero) begin
                        result_r <= {sign_r, 31'b0};
                    end else if (!fx_norm) begin
                        fx    <= fx << 1;
                        s_cnt <= s_cnt + 1'b1;
                    end
                end
                PACK:    result_r <= packed_f;
                DONE:    ;
                default: ;
            endcase
        end
    end

endmodule
